id_stage_pipe: RTL and testbench

- Parametrised, pipelined RV32I decode stage that owns the ID/EX pipeline register.
- Accepts instructions from IF over a valid/ready handshake and decodes them (controls, register addresses, XLEN-wide immediate).
- Detects load-use hazards against its own registered output and inserts a one-cycle bubble. Supports flush from branch resolution.
- Sits between the IF stage and the EX stage.

---
 rtl/id_stage_pipe_pkg.sv | 97 +++++++++
 rtl/id_stage_pipe_decode_core.sv | 113 +++++++++++
 rtl/id_stage_pipe.sv | 144 ++++++++++++++
 tb/tb_id_stage_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - shared decode types, opcodes and immediate helpers
// Purpose: control encodings, RV32I opcode constants and the immediate
// formatter used by id_decode_core and id_stage_pipe.
// Ports: none (package).
package id_stage_pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } ctr_branch_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } ctr_alu_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // 32-bit immediate; the caller sign-extends to XLEN from bit 31.
  function automatic logic [31:0] imm32(input imm_fmt_t fmt, input logic [31:0] insn);
    logic [31:0] r;
    r = '0;
    case (fmt)
      IMM_I:   r = {{20{insn[31]}}, insn[31:20]};
      IMM_S:   r = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   r = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   r = {insn[31:12], 12'b0};
      IMM_J:   r = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // alt is insn[30]; it selects SUB only for register-register ops.
  function automatic ctr_alu_t alu_op(input logic [2:0] f3, input logic alt, input logic allow_sub);
    ctr_alu_t r;
    r = ALU_ADD;
    case (f3)
      3'b000: r = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic ctr_branch_t branch_op(input logic [2:0] f3);
    ctr_branch_t r;
    case (f3)
      3'b000:  r = BR_EQ;
      3'b001:  r = BR_NE;
      3'b100:  r = BR_LT;
      3'b101:  r = BR_GE;
      3'b110:  r = BR_LTU;
      3'b111:  r = BR_GEU;
      default: r = BR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_stage_pipe_decode_core.sv
// rtl/id_stage_pipe_decode_core.sv - combinational RV32I instruction decoder
// Purpose: instruction word to controls, register addresses, XLEN immediate.
// Ports: insn (in); reg_write_en, data_write_en, reg_select, mem_read,
// branch_ctr, alu_ctr, rs1, rs2, rd, imm, illegal (out).
module id_decode_core
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [ILEN-1:0]   insn,
  output logic              reg_write_en,
  output logic              data_write_en,
  output logic              reg_select,
  output logic              mem_read,
  output ctr_branch_t       branch_ctr,
  output ctr_alu_t          alu_ctr,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rd_f;
  imm_fmt_t   fmt;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;

  assign opcode = insn[6:0];
  assign f3     = insn[14:12];
  assign rd_f   = insn[11:7];

  always_comb begin
    data_write_en = 1'b0;
    reg_select    = 1'b0;
    mem_read      = 1'b0;
    branch_ctr    = BR_NONE;
    alu_ctr       = ALU_ADD;
    fmt           = IMM_NONE;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    use_rd        = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_LUI: begin
        fmt     = IMM_U;
        use_rd  = 1'b1;
        alu_ctr = ALU_PASSB;
      end
      OP_AUIPC: begin
        fmt    = IMM_U;
        use_rd = 1'b1;
      end
      OP_JAL: begin
        fmt        = IMM_J;
        use_rd     = 1'b1;
        branch_ctr = BR_JUMP;
      end
      OP_JALR: begin
        fmt        = IMM_I;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        branch_ctr = BR_JUMP;
      end
      OP_BRANCH: begin
        fmt        = IMM_B;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        alu_ctr    = ALU_SUB;
        branch_ctr = branch_op(f3);
      end
      OP_LOAD: begin
        fmt        = IMM_I;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        mem_read   = 1'b1;
        reg_select = 1'b1;
      end
      OP_STORE: begin
        fmt           = IMM_S;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        data_write_en = 1'b1;
      end
      OP_IMM: begin
        fmt     = IMM_I;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        alu_ctr = alu_op(f3, insn[30], 1'b0);
      end
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        alu_ctr = alu_op(f3, insn[30], 1'b1);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Unused source fields read as x0 so they never match a load destination.
  assign rs1          = use_rs1 ? REG_AW'(insn[19:15]) : '0;
  assign rs2          = use_rs2 ? REG_AW'(insn[24:20]) : '0;
  assign rd           = use_rd  ? REG_AW'(rd_f)        : '0;
  assign reg_write_en = use_rd && (rd_f != 5'd0);
  assign imm          = XLEN'($signed(imm32(fmt, insn[31:0])));

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage owning the ID/EX pipeline register
// Purpose: valid/ready decode stage with load-use bubble and flush.
// Optional feature macro: ID_PERF_CNT_EN adds stall_cnt / bubble_cnt.
// Ports: clk, rst (sync active-low); in_valid/in_ready/in_insn/in_pc from IF;
// flush; out_valid/out_ready and registered out_* fields to EX;
// stall_cnt, bubble_cnt (only with ID_PERF_CNT_EN).
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_insn,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_reg_write_en,
  output logic              out_data_write_en,
  output logic              out_reg_select,
  output logic              out_mem_read,
  output logic [2:0]        out_branch_ctr,
  output logic [3:0]        out_alu_ctr,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal
`ifdef ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  if (CNT_W < 1 || XLEN < 32 || ILEN < 32) begin : g_bad_param
    $error("id_stage_pipe: unsupported parameter set");
  end

  logic              d_reg_write_en;
  logic              d_data_write_en;
  logic              d_reg_select;
  logic              d_mem_read;
  ctr_branch_t       d_branch_ctr;
  ctr_alu_t          d_alu_ctr;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic [REG_AW-1:0] d_rd;
  logic [XLEN-1:0]   d_imm;
  logic              d_illegal;

  logic advance;
  logic hazard;
  logic accept;

  id_decode_core #(
    .XLEN   (XLEN),
    .ILEN   (ILEN),
    .REG_AW (REG_AW)
  ) u_decode (
    .insn          (in_insn),
    .reg_write_en  (d_reg_write_en),
    .data_write_en (d_data_write_en),
    .reg_select    (d_reg_select),
    .mem_read      (d_mem_read),
    .branch_ctr    (d_branch_ctr),
    .alu_ctr       (d_alu_ctr),
    .rs1           (d_rs1),
    .rs2           (d_rs2),
    .rd            (d_rd),
    .imm           (d_imm),
    .illegal       (d_illegal)
  );

  // A load still sitting in the register cannot forward to its consumer;
  // holding the consumer one cycle lets the load reach EX/MEM first.
  assign hazard = in_valid && out_valid && out_mem_read && (out_rd != '0) &&
                  ((out_rd == d_rs1) || (out_rd == d_rs2));

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush && rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid         <= 1'b0;
      out_pc            <= '0;
      out_reg_write_en  <= 1'b0;
      out_data_write_en <= 1'b0;
      out_reg_select    <= 1'b0;
      out_mem_read      <= 1'b0;
      out_branch_ctr    <= 3'd0;
      out_alu_ctr       <= 4'd0;
      out_rs1           <= '0;
      out_rs2           <= '0;
      out_rd            <= '0;
      out_imm           <= '0;
      out_illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      // Without an accept the slot turns into a bubble; data fields hold.
      out_valid <= accept;
      if (accept) begin
        out_pc            <= in_pc;
        out_reg_write_en  <= d_reg_write_en;
        out_data_write_en <= d_data_write_en;
        out_reg_select    <= d_reg_select;
        out_mem_read      <= d_mem_read;
        out_branch_ctr    <= d_branch_ctr;
        out_alu_ctr       <= d_alu_ctr;
        out_rs1           <= d_rs1;
        out_rs2           <= d_rs2;
        out_rd            <= d_rd;
        out_imm           <= d_imm;
        out_illegal       <= d_illegal;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !flush) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (advance && !accept && !flush && in_valid) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ILEN-1:0]   in_insn;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic              out_reg_write_en;
  logic              out_data_write_en;
  logic              out_reg_select;
  logic              out_mem_read;
  logic [2:0]        out_branch_ctr;
  logic [3:0]        out_alu_ctr;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_imm;
  logic              out_illegal;
`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  snap_stall;
  logic [CNT_W-1:0]  snap_bubble;
`endif

  int checks;
  int failures;

  id_stage_pipe #(
    .XLEN   (XLEN),
    .ILEN   (ILEN),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_insn           (in_insn),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_reg_write_en  (out_reg_write_en),
    .out_data_write_en (out_data_write_en),
    .out_reg_select    (out_reg_select),
    .out_mem_read      (out_mem_read),
    .out_branch_ctr    (out_branch_ctr),
    .out_alu_ctr       (out_alu_ctr),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_rd            (out_rd),
    .out_imm           (out_imm),
    .out_illegal       (out_illegal)
`ifdef ID_PERF_CNT_EN
    ,
    .stall_cnt         (stall_cnt),
    .bubble_cnt        (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic        rwe;
    logic        dwe;
    logic        sel;
    logic        mr;
    logic [2:0]  br;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [63:0] pc);
    in_valid = v;
    in_insn  = insn;
    in_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [159:0] bundle();
    return {5'd0, out_pc, out_reg_write_en, out_data_write_en, out_reg_select, out_mem_read,
            out_branch_ctr, out_alu_ctr, out_rs1, out_rs2, out_rd, out_imm, out_illegal};
  endfunction

  function automatic logic [159:0] exp_bundle(input vec_t v, input logic [63:0] pc);
    return {5'd0, pc, v.rwe, v.dwe, v.sel, v.mr, v.br, v.alu, v.rs1, v.rs2, v.rd, v.imm, v.ill};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    //            insn          rwe  dwe  sel  mr   br    alu    rs1   rs2   rd    imm                     ill
    vecs[0]  = '{32'hFFF00093, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0,  5'd0, 5'd0, 5'd1,  64'hFFFFFFFFFFFFFFFF, 1'b0}; // addi x1,x0,-1
    vecs[1]  = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0,  5'd0, 5'd0, 5'd0,  64'h0,                1'b1}; // unknown opcode
    vecs[2]  = '{32'h0000A283, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0,  5'd1, 5'd0, 5'd5,  64'h0,                1'b0}; // lw x5,0(x1)
    vecs[3]  = '{32'h0021A423, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  5'd3, 5'd2, 5'd0,  64'h8,                1'b0}; // sw x2,8(x3)
    vecs[4]  = '{32'hFE208EE3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1,  5'd1, 5'd2, 5'd0,  64'hFFFFFFFFFFFFFFFC, 1'b0}; // beq x1,x2,-4
    vecs[5]  = '{32'h800003B7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd10, 5'd0, 5'd0, 5'd7,  64'hFFFFFFFF80000000, 1'b0}; // lui x7,0x80000
    vecs[6]  = '{32'h0080006F, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 4'd0,  5'd0, 5'd0, 5'd0,  64'h8,                1'b0}; // jal x0,8
    vecs[7]  = '{32'h40228333, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1,  5'd5, 5'd2, 5'd6,  64'h0,                1'b0}; // sub x6,x5,x2
    vecs[8]  = '{32'h40525193, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd7,  5'd4, 5'd0, 5'd3,  64'h405,              1'b0}; // srai x3,x4,5
    vecs[9]  = '{32'h12345517, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0,  5'd0, 5'd0, 5'd10, 64'h12345000,         1'b0}; // auipc x10,0x12345
    vecs[10] = '{32'h004100E7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 4'd0,  5'd2, 5'd0, 5'd1,  64'h4,                1'b0}; // jalr x1,4(x2)

    // Reset held for three edges with IF presenting an instruction.
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 64'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_valid_ready", {158'd0, out_valid, in_ready}, 160'd0);
    end
    check("reset_outputs", bundle(), 160'd0);
    rst = 1'b1;
    #1;
    check("release_in_ready", {159'd0, in_ready}, 160'd1);
    tick();
    check("release_accept", {154'd0, out_valid, out_rd}, {154'd0, 1'b1, 5'd1});

    // Decode table: one instruction per cycle, EX always ready.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].insn, 64'h1000 + 64'(4 * i));
      check($sformatf("vec%0d_in_ready", i), {159'd0, in_ready}, 160'd1);
      tick();
      check($sformatf("vec%0d_valid", i), {159'd0, out_valid}, 160'd1);
      check($sformatf("vec%0d_fields", i), bundle(), exp_bundle(vecs[i], 64'h1000 + 64'(4 * i)));
    end

`ifdef ID_PERF_CNT_EN
    snap_stall  = stall_cnt;
    snap_bubble = bubble_cnt;
`endif
    // Load-use pair twice: exactly one bubble each time.
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 32'h0000A283, 64'h2000);
      check("lu_load_ready", {159'd0, in_ready}, 160'd1);
      tick();
      drive(1'b1, 32'h00228333, 64'h2004);
      check("lu_hazard_ready", {159'd0, in_ready}, 160'd0);
      tick();
      check("lu_bubble", {159'd0, out_valid}, 160'd0);
      check("lu_after_bubble_ready", {159'd0, in_ready}, 160'd1);
      tick();
      check("lu_consumer", {90'd0, out_valid, out_rd, out_pc}, {90'd0, 1'b1, 5'd6, 64'h2004});
    end
    // Load to x0 never stalls its consumer.
    drive(1'b1, 32'h0000A003, 64'h2100);
    tick();
    drive(1'b1, 32'h00200333, 64'h2104);
    check("lu_x0_ready", {159'd0, in_ready}, 160'd1);
    tick();
    check("lu_x0_consumer", {154'd0, out_valid, out_rd}, {154'd0, 1'b1, 5'd6});
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("lu_drain", {159'd0, out_valid}, 160'd0);
`ifdef ID_PERF_CNT_EN
    check("perf_bubble_loaduse", {128'd0, bubble_cnt - snap_bubble}, 160'd2);
    check("perf_stall_loaduse", {128'd0, stall_cnt - snap_stall}, 160'd2);
`endif

    // Backpressure: EX stalls four cycles with the register full.
    drive(1'b1, 32'h00500413, 64'h3000);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h00600493, 64'h3004);
`ifdef ID_PERF_CNT_EN
    snap_stall = stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", {159'd0, in_ready}, 160'd0);
      tick();
      check("bp_hold", {90'd0, out_valid, out_rd, out_imm}, {90'd0, 1'b1, 5'd8, 64'd5});
    end
`ifdef ID_PERF_CNT_EN
    check("perf_stall_bp", {128'd0, stall_cnt - snap_stall}, 160'd4);
`endif
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {159'd0, in_ready}, 160'd1);
    tick();
    check("bp_next", {90'd0, out_valid, out_rd, out_imm}, {90'd0, 1'b1, 5'd9, 64'd6});
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("bp_no_dup", {159'd0, out_valid}, 160'd0);

    // Flush with a valid register and an incoming instruction.
    drive(1'b1, 32'h00700593, 64'h4000);
    tick();
    flush     = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h00900613, 64'h4004);
    check("flush_in_ready", {159'd0, in_ready}, 160'd0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    check("flush_kill", {154'd0, out_valid, out_rd}, {154'd0, 1'b0, 5'd11});
    tick();
    tick();
    check("flush_dropped", {154'd0, out_valid, out_rd}, {154'd0, 1'b0, 5'd11});

    // Reset mid-operation discards the in-flight instruction.
    drive(1'b1, 32'h00500413, 64'h5000);
    tick();
    check("midrst_loaded", {154'd0, out_valid, out_rd}, {154'd0, 1'b1, 5'd8});
    rst = 1'b0;
    drive(1'b1, 32'h00600493, 64'h5004);
    check("midrst_in_ready", {159'd0, in_ready}, 160'd0);
    tick();
    check("midrst_cleared", bundle(), 160'd0);
    check("midrst_valid", {159'd0, out_valid}, 160'd0);
`ifdef ID_PERF_CNT_EN
    check("perf_reset", {96'd0, stall_cnt, bubble_cnt}, 160'd0);
`endif
    rst = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("midrst_idle", {159'd0, out_valid}, 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
